// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core memory subsystem.
package simple_pkg;

    localparam int unsigned WORD_W = 16;

    // Main-memory responder FSM states
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAcc,
        StResp
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x WORD_W, 1-cycle registered read.
// The read register holds its value between reads; array contents are not reset.
module mem_array
    import simple_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: loads only on a read, otherwise holds the last word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the SIMPLE core's mem_e/mem_w strobes.
// One word access per mem_e rising edge, WAIT_STATES extra cycles before the array access,
// 1-cycle rvalid pulse on completion. A sequential program loader fills the array while
// the core is not executing.
// Optional feature: define MEM_BOUNDS_CHECK_EN to suppress out-of-range accesses, return
// zero read data for them and expose an err pulse alongside rvalid.
module main_mem_responder
    import simple_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec,
    input  logic              mem_e,
    input  logic              mem_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              ovr,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

    mem_state_t        state;
    logic              mem_e_q;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              wr_q;
    logic [IDX_W-1:0]  ptr;

    logic              req;
    logic              acc;
    logic              ld_fire;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    assign req      = mem_e & ~mem_e_q;
    assign acc      = (state == StAcc);
    assign ld_ready = (state == StIdle) & ~exec & ~req;
    assign ld_fire  = ld_valid & ld_ready;

    // Out-of-range addresses fold back into the implemented depth
    assign acc_idx = IDX_W'(32'(addr_q) % DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
    logic in_range;
    logic oob_q;

    assign in_range = (32'(addr_q) < DEPTH);
    assign acc_we   = acc & wr_q & in_range;
    // A read that fell outside the array reports zero until the next read
    assign rdata    = oob_q ? '0 : ram_rdata;

    // Track range of the last read and pulse err together with rvalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oob_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= acc & ~in_range;
            if (acc && !wr_q) begin
                oob_q <= ~in_range;
            end
        end
    end
`else
    assign acc_we = acc & wr_q;
    assign rdata  = ram_rdata;
`endif

    // Loader only writes in IDLE, so the access path owns the port whenever it is in ACC
    assign ram_we    = acc_we | ld_fire;
    assign ram_re    = acc & ~wr_q;
    assign ram_addr  = acc ? acc_idx : ptr;
    assign ram_wdata = acc ? wdata_q : ld_data;

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Access FSM with registered busy/rvalid/ovr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            mem_e_q <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            busy    <= 1'b0;
            rvalid  <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            mem_e_q <= mem_e;
            rvalid  <= 1'b0;
            // A new edge during an access is dropped but remembered
            if (req && state != StIdle) begin
                ovr <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wr_q    <= mem_w;
                        busy    <= 1'b1;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES == 0) ? StAcc : StWait;
                    end
                end
                StWait: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= StAcc;
                    end
                end
                StAcc: begin
                    rvalid <= 1'b1;
                    state  <= StResp;
                end
                StResp: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Loader pointer; ld_start wins over an increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (ld_start) begin
            ptr <= '0;
        end else if (ld_fire) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every rvalid.
`timescale 1ns/1ps
module tb_main_mem_responder;
    import simple_pkg::*;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam int unsigned DEPTH = 128;
`else
    localparam int unsigned DEPTH = 256;
`endif
    localparam int unsigned WS = 1;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        exec     = 1'b0;
    logic        mem_e    = 1'b0;
    logic        mem_w    = 1'b0;
    logic [7:0]  addr     = '0;
    logic [15:0] wdata    = '0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data  = '0;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        ovr;
    logic        ld_ready;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        err;
`endif

    main_mem_responder #(
        .ADDR_W      (8),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .exec     (exec),
        .mem_e    (mem_e),
        .mem_w    (mem_w),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy),
        .ovr      (ovr),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready)
`ifdef MEM_BOUNDS_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [DEPTH];
    int          ptr_m   = 0;
    logic [15:0] last_rd = '0;
    int          checks  = 0;
    int          errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && rvalid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("rdata", rdata, e.data);
                chk("rvalid_cycle", cyc, e.cyc);
`ifdef MEM_BOUNDS_CHECK_EN
                chk("err", err, e.err);
`endif
            end
        end
    end

    // Model one access and queue its response; call right after driving the request
    task automatic push_exp(input bit w, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        int   idx;
        bit   oob;
        idx = int'(a) % int'(DEPTH);
        oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (int'(a) >= int'(DEPTH));
`endif
        if (w) begin
            if (!oob) mdl[idx] = d;
        end else begin
            last_rd = oob ? 16'h0000 : mdl[idx];
        end
        e.data = last_rd;
        e.err  = oob;
        e.cyc  = cyc + int'(WS) + 2;
        q.push_back(e);
    endtask

    task automatic access(input bit w, input logic [7:0] a, input logic [15:0] d,
                          input int hold, output int bcnt);
        @(posedge clk); #1;
        mem_e = 1'b1; mem_w = w; addr = a; wdata = d;
        push_exp(w, a, d);
        bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            if (k + 1 >= hold) mem_e = 1'b0;
        end
    endtask

    task automatic load(input logic [15:0] d);
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_data = d;
        @(negedge clk);
        chk("ld_ready", ld_ready, 1);
        mdl[ptr_m] = d;
        ptr_m = (ptr_m + 1) % int'(DEPTH);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic pulse_ld_start();
        @(posedge clk); #1; ld_start = 1'b1;
        @(posedge clk); #1; ld_start = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        int b;
        #2 rst = 1'b0;
        #10;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        @(negedge clk) rst = 1'b1;

        // 1: load four words, then read addr 2
        pulse_ld_start();
        load(16'h1111); load(16'h2222); load(16'h3333); load(16'h4444);
        @(posedge clk); #1 exec = 1'b1;
        #1 chk("exec_blocks_ld_ready", ld_ready, 0);
        access(1'b0, 8'd2, 16'h0, 1, b);
        chk("t1_busy_cycles", b, 3);

        // 2: write then read back
        access(1'b1, 8'd5, 16'hBEEF, 1, b);
        chk("t2_wr_busy_cycles", b, 3);
        access(1'b0, 8'd5, 16'h0, 1, b);
        chk("t2_rd_busy_cycles", b, 3);

        // 3: held mem_e is one request; a second edge while busy sets ovr
        chk("t3_ovr_clear", ovr, 0);
        access(1'b0, 8'd1, 16'h0, 3, b);
        chk("t3_held_busy_cycles", b, 3);
        chk("t3_ovr_still_clear", ovr, 0);
        @(posedge clk); #1;
        mem_e = 1'b1; mem_w = 1'b0; addr = 8'd3;
        push_exp(1'b0, 8'd3, 16'h0);
        @(posedge clk); #1 mem_e = 1'b0;
        @(posedge clk); #1 mem_e = 1'b1;
        @(posedge clk); #1 mem_e = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("t3_ovr_set", ovr, 1);

        // Loader vs request, and exec rising against an offered word
        exec = 1'b0;
        pulse_ld_start();
        load(16'h0A0A);
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_data = 16'h7777;
        mem_e = 1'b1; mem_w = 1'b0; addr = 8'd0;
        push_exp(1'b0, 8'd0, 16'h0);
        #1 chk("req_beats_loader", ld_ready, 0);
        @(posedge clk); #1;
        ld_valid = 1'b0; mem_e = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        ld_valid = 1'b1; ld_data = 16'h6666; exec = 1'b1;
        #1 chk("exec_drops_ld_ready", ld_ready, 0);
        @(posedge clk); #1;
        ld_valid = 1'b0; exec = 1'b0;
        load(16'h8888);
        access(1'b0, 8'd1, 16'h0, 1, b);
        access(1'b0, 8'd0, 16'h0, 1, b);

        // 4: pointer wrap after DEPTH words, ld_start mid-load
        pulse_ld_start();
        for (int i = 0; i <= int'(DEPTH); i++) load(16'h5000 + 16'(i));
        load(16'hC001); load(16'hC002); load(16'hC003);
        pulse_ld_start();
        load(16'hA5A5);
        @(posedge clk); #1 exec = 1'b1;
        access(1'b0, 8'd0, 16'h0, 1, b);
        access(1'b0, 8'd1, 16'h0, 1, b);
        access(1'b0, 8'd4, 16'h0, 1, b);
        access(1'b0, 8'(DEPTH - 1), 16'h0, 1, b);

        // 5: reset during WAIT aborts the write
        access(1'b1, 8'd9, 16'h0909, 1, b);
        @(posedge clk); #1;
        mem_e = 1'b1; mem_w = 1'b1; addr = 8'd9; wdata = 16'h1234;
        @(posedge clk); #1 mem_e = 1'b0;
        @(negedge clk);
        chk("t5_busy_in_wait", busy, 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rvalid", rvalid, 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_ovr", ovr, 0);
        last_rd = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        access(1'b0, 8'd9, 16'h0, 1, b);
        chk("t5_rd_busy_cycles", b, 3);

`ifdef MEM_BOUNDS_CHECK_EN
        // 6: out-of-range accesses are suppressed and flagged
        access(1'b1, 8'd72, 16'h7272, 1, b);
        access(1'b1, 8'd200, 16'hDEAD, 1, b);
        access(1'b0, 8'd72, 16'h0, 1, b);
        access(1'b0, 8'd200, 16'h0, 1, b);
`endif

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
